uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter between NUM_REQ byte producers. It accepts one byte at a time over a valid/ready handshake and drives the transmitter's start/data inputs. It then holds off further grants until the transmitter reports frame completion through its done-tick output, or until a watchdog expires. It sits between on-chip producers (command responder, debug logger, status reporter) and the shared UART transmitter.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DBIT_WIDTH, 8, data bits per frame; matches transmitter DBIT_WIDTH
- DONE_PULSES, 2, tx_done_tick pulses the transmitter issues per frame (one after the data bits, one after the stop bit)
- TIMEOUT_CYCLES, 65536, watchdog limit in clk cycles spent in WAIT
- clk  in  1  system clock; one clock domain, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid; held until matching req_ready pulse
- req_data  in  NUM_REQ*DBIT_WIDTH  byte for requester i at [i*DBIT_WIDTH +: DBIT_WIDTH]
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_data  out  DBIT_WIDTH  byte to transmitter; stable from tx_start until frame end
- tx_done_tick  in  1  transmitter done pulse
- busy  out  1  high while a frame is outstanding (state != IDLE)
- gnt_id  out  clog2(NUM_REQ)  index of last granted requester
- frame_done  out  1  one-cycle pulse on normal frame completion
- err_timeout  out  1  one-cycle pulse on watchdog expiry

## Operation
- States: IDLE, START, WAIT. All outputs are registered.
- **IDLE:**
  - If any req_valid is high, select the first set bit searching from the rotating pointer ptr upward, with modulo NUM_REQ wrap.
  - Next cycle: state=START, tx_start=1, tx_data=selected req_data, req_ready[sel]=1, gnt_id=sel, ptr=(sel+1) mod NUM_REQ, busy=1.
  - If no req_valid is high, remain in IDLE.
- **START:** lasts exactly one cycle. Next state is WAIT, with tx_start=0 and req_ready=0. The done counter and watchdog counter clear to 0.
- **WAIT:**
  - Each cycle with tx_done_tick=1 increments the done counter.
  - When a tick arrives with the counter already at DONE_PULSES-1: next state IDLE, frame_done=1, busy=0.
  - Otherwise the watchdog increments every cycle. At TIMEOUT_CYCLES-1 without completion: next state IDLE, err_timeout=1, busy=0.
- tx_done_tick is ignored in IDLE and START.
- tx_data holds its value until the next grant. It is never cleared by completion.
- Counter widths:
  - done counter: clog2(DONE_PULSES+1) bits
  - watchdog: clog2(TIMEOUT_CYCLES) bits
  - Neither counter wraps within a frame.

## Timing
- Reset values: state=IDLE, ptr=0, tx_start=0, tx_data=0, req_ready=0, busy=0, gnt_id=0, frame_done=0, err_timeout=0, counters=0.
- Grant latency: valid seen in IDLE at cycle T; req_ready, tx_start and busy assert at T+1. A requester may change req_data or deassert req_valid from T+2.
- Back-to-back frames: final done tick at cycle D, frame_done at D+1 (state IDLE), next tx_start at D+2.
- Simultaneous final done tick and watchdog expiry: completion wins, frame_done=1, err_timeout=0.
- A requester that keeps req_valid high after its ready pulse is treated as offering a new byte. It is served again only after every other pending requester has had a turn.
- Reset asserted mid-frame: all outputs return to reset values on the next edge. No tx_start is issued, and the partial frame is abandoned.
- At most one of req_ready bits is ever high. tx_start is never high for two consecutive cycles.

## Test plan
- **Single byte:** req_valid[2]=1 with data 0xA5, then a done tick 20 and 180 cycles after tx_start. Expect:
  - req_ready=4'b0100 and tx_start=1 one cycle later, tx_data=0xA5, gnt_id=2
  - frame_done exactly one cycle after the second tick
  - busy low afterwards
- **Round robin:** all four requesters valid continuously, each done tick pair supplied. Expect:
  - grant order 0,1,2,3,0
  - tx_start spacing of final tick +2 cycles
- **Pointer wrap:** after a grant to requester 3, assert req_valid=4'b0011. Expect grant to 0, then 1.
- **Watchdog:** TIMEOUT_CYCLES=32, one request, no done ticks. Expect:
  - err_timeout pulse 32 cycles after entering WAIT, frame_done=0
  - IDLE reached; the next request is granted normally
- **Race:** TIMEOUT_CYCLES=32 with the second done tick on the last watchdog cycle. Expect frame_done=1, err_timeout=0.
- **Reset mid-frame:** rst=1 for one cycle during WAIT. Expect:
  - all outputs at reset values next cycle
  - ptr=0, so a pending request from requester 0 is granted first

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// A grant holds off further grants until the frame's done ticks arrive or the watchdog fires.
module uart_tx_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int DBIT_WIDTH     = 8,
   parameter int DONE_PULSES    = 2,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DBIT_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic                          tx_start_o,
   output logic [DBIT_WIDTH-1:0]         tx_data_o,
   input  logic                          tx_done_tick_i,
   output logic                          busy_o,
   output logic [$clog2(NUM_REQ)-1:0]    gnt_id_o,
   output logic                          frame_done_o,
   output logic                          err_timeout_o
);
   localparam int IDW = $clog2(NUM_REQ);
   localparam int DCW = $clog2(DONE_PULSES + 1);
   localparam int WDW = $clog2(TIMEOUT_CYCLES);
   localparam logic [IDW-1:0] ID_LAST   = IDW'(NUM_REQ - 1);
   localparam logic [DCW-1:0] DONE_LAST = DCW'(DONE_PULSES - 1);
   localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

   state_t                state_q, state_d;
   logic [IDW-1:0]        ptr_q, ptr_d;
   logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
   logic                  tx_start_q, tx_start_d;
   logic [DBIT_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  busy_q, busy_d;
   logic [IDW-1:0]        gnt_id_q, gnt_id_d;
   logic                  frame_done_q, frame_done_d;
   logic                  err_timeout_q, err_timeout_d;
   logic [DCW-1:0]        done_cnt_q, done_cnt_d;
   logic [WDW-1:0]        wd_cnt_q, wd_cnt_d;

   logic [DBIT_WIDTH-1:0] req_bytes [NUM_REQ];
   logic [IDW-1:0]        cand_idx  [NUM_REQ];
   logic                  sel_found;
   logic [IDW-1:0]        sel_idx;

   // cand_idx[k] is the requester k places above the round-robin pointer
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign req_bytes[gi] = req_data_i[gi*DBIT_WIDTH +: DBIT_WIDTH];
         assign cand_idx[gi]  = IDW'((int'(ptr_q) + gi) % NUM_REQ);
      end
   endgenerate

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!sel_found && req_valid_i[cand_idx[k]]) begin
            sel_found = 1'b1;
            sel_idx   = cand_idx[k];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      req_ready_d   = '0;
      tx_start_d    = 1'b0;
      tx_data_d     = tx_data_q;
      gnt_id_d      = gnt_id_q;
      frame_done_d  = 1'b0;
      err_timeout_d = 1'b0;
      done_cnt_d    = done_cnt_q;
      wd_cnt_d      = wd_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (sel_found) begin
               state_d              = S_START;
               tx_start_d           = 1'b1;
               tx_data_d            = req_bytes[sel_idx];
               req_ready_d[sel_idx] = 1'b1;
               gnt_id_d             = sel_idx;
               ptr_d                = (sel_idx == ID_LAST) ? '0 : sel_idx + 1'b1;
            end
         end
         S_START: begin
            state_d    = S_WAIT;
            done_cnt_d = '0;
            wd_cnt_d   = '0;
         end
         S_WAIT: begin
            if (tx_done_tick_i) begin
               done_cnt_d = done_cnt_q + 1'b1;
            end
            // completion is checked first so a final tick on the last watchdog cycle wins
            if (tx_done_tick_i && done_cnt_q == DONE_LAST) begin
               state_d      = S_IDLE;
               frame_done_d = 1'b1;
            end else if (wd_cnt_q == WD_LAST) begin
               state_d       = S_IDLE;
               err_timeout_d = 1'b1;
            end else begin
               wd_cnt_d = wd_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         ptr_q         <= '0;
         req_ready_q   <= '0;
         tx_start_q    <= 1'b0;
         tx_data_q     <= '0;
         busy_q        <= 1'b0;
         gnt_id_q      <= '0;
         frame_done_q  <= 1'b0;
         err_timeout_q <= 1'b0;
         done_cnt_q    <= '0;
         wd_cnt_q      <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         req_ready_q   <= req_ready_d;
         tx_start_q    <= tx_start_d;
         tx_data_q     <= tx_data_d;
         busy_q        <= busy_d;
         gnt_id_q      <= gnt_id_d;
         frame_done_q  <= frame_done_d;
         err_timeout_q <= err_timeout_d;
         done_cnt_q    <= done_cnt_d;
         wd_cnt_q      <= wd_cnt_d;
      end
   end

   assign req_ready_o   = req_ready_q;
   assign tx_start_o    = tx_start_q;
   assign tx_data_o     = tx_data_q;
   assign busy_o        = busy_q;
   assign gnt_id_o      = gnt_id_q;
   assign frame_done_o  = frame_done_q;
   assign err_timeout_o = err_timeout_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (watchdog 200 and 32 cycles) share one stimulus
// and are checked every cycle against a frame-level model, plus directed literal checks.
module tb_uart_tx_arbiter;
   localparam int NR = 4;
   localparam int DW = 8;
   localparam int NI = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst  = 1'b1;
   logic [NR-1:0]     rv   = '0;
   logic [NR*DW-1:0]  rd   = '0;
   logic              tick = 1'b0;

   logic [NR-1:0] rdy_w  [NI];
   logic          st_w   [NI];
   logic [DW-1:0] dat_w  [NI];
   logic          busy_w [NI];
   logic [1:0]    gnt_w  [NI];
   logic          fd_w   [NI];
   logic          to_w   [NI];

   genvar gi;
   generate
      for (gi = 0; gi < NI; gi++) begin : g_dut
         uart_tx_arbiter #(
            .NUM_REQ(NR), .DBIT_WIDTH(DW), .DONE_PULSES(2),
            .TIMEOUT_CYCLES(gi == 0 ? 200 : 32)
         ) u_dut (
            .clk_i(clk), .rst_i(rst), .req_valid_i(rv), .req_data_i(rd),
            .req_ready_o(rdy_w[gi]), .tx_start_o(st_w[gi]), .tx_data_o(dat_w[gi]),
            .tx_done_tick_i(tick), .busy_o(busy_w[gi]), .gnt_id_o(gnt_w[gi]),
            .frame_done_o(fd_w[gi]), .err_timeout_o(to_w[gi])
         );
      end
   endgenerate

   function automatic int to_of(input int m);
      return (m == 0) ? 200 : 32;
   endfunction

   // Model: a frame is a grant cycle followed by wait cycles; it ends when the
   // second done tick is seen in a wait cycle, or after to_of(m) wait cycles.
   int            m_ptr   [NI];
   bit            m_act   [NI];
   int            m_age   [NI];
   int            m_ticks [NI];
   logic [NR-1:0] e_rdy   [NI];
   logic          e_st    [NI];
   logic [DW-1:0] e_dat   [NI];
   logic          e_busy  [NI];
   logic [1:0]    e_gnt   [NI];
   logic          e_fd    [NI];
   logic          e_to    [NI];
   bit            m_valid = 1'b0;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc_n = 0;

   always @(posedge clk) begin
      int sel;
      logic [1:0] c;
      cyc_n++;
      for (int m = 0; m < NI; m++) begin
         e_rdy[m] = '0; e_st[m] = 1'b0; e_fd[m] = 1'b0; e_to[m] = 1'b0;
         if (rst) begin
            m_valid = 1'b1;
            m_act[m] = 1'b0; m_ptr[m] = 0;
            e_dat[m] = '0; e_busy[m] = 1'b0; e_gnt[m] = '0;
         end else if (!m_act[m]) begin
            sel = -1;
            for (int k = 0; k < NR; k++) begin
               c = 2'((m_ptr[m] + k) % NR);
               if (sel < 0 && rv[c]) sel = int'(c);
            end
            if (sel >= 0) begin
               m_act[m] = 1'b1; m_age[m] = 0; m_ticks[m] = 0;
               e_st[m] = 1'b1;
               e_rdy[m] = NR'(1 << sel);
               e_dat[m] = DW'(rd >> (sel * DW));
               e_gnt[m] = 2'(sel);
               m_ptr[m] = (sel + 1) % NR;
               e_busy[m] = 1'b1;
            end
         end else if (m_age[m] == 0) begin
            m_age[m] = 1;
         end else begin
            if (tick) m_ticks[m]++;
            if (tick && m_ticks[m] == 2) begin
               m_act[m] = 1'b0; e_fd[m] = 1'b1; e_busy[m] = 1'b0;
            end else if (m_age[m] == to_of(m)) begin
               m_act[m] = 1'b0; e_to[m] = 1'b1; e_busy[m] = 1'b0;
            end else begin
               m_age[m]++;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [17:0] a, e;
      if (m_valid) begin
         for (int m = 0; m < NI; m++) begin
            a = {rdy_w[m], st_w[m], dat_w[m], busy_w[m], gnt_w[m], fd_w[m], to_w[m]};
            e = {e_rdy[m], e_st[m], e_dat[m], e_busy[m], e_gnt[m], e_fd[m], e_to[m]};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL model dut%0d cycle %0d: {rdy,start,data,busy,gnt,fd,to} got %b need %b",
                        m, cyc_n, a, e);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h need %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; rv = '0; tick = 1'b0;
      cyc(1);
      rst = 1'b0;
   endtask

   task automatic wait_start(input int m, input string nm);
      int w;
      w = 0;
      while (!st_w[m] && w < 40) begin
         cyc(1);
         w++;
      end
      n_cmp++;
      if (!st_w[m]) begin
         n_bad++;
         $display("FAIL %s: tx_start not seen within 40 cycles", nm);
      end
   endtask

   // ticks in the 1st and 3rd cycle after tx_start; returns one cycle after the final tick
   task automatic two_ticks();
      cyc(1); tick = 1'b1; cyc(1); tick = 1'b0;
      cyc(1); tick = 1'b1; cyc(1); tick = 1'b0;
   endtask

   initial begin
      int last_end;
      rst = 1'b1;
      cyc(3);
      chk("reset_busy", busy_w[0], 0);
      chk("reset_gnt", gnt_w[0], 0);
      chk("reset_data", dat_w[0], 0);
      chk("reset_start", st_w[1], 0);
      rst = 1'b0;

      // single byte from requester 2, done ticks 20 and 180 cycles after tx_start
      rv = 4'b0100; rd = 32'h00A5_0000;
      cyc(1);
      chk("sb_ready", rdy_w[0], 4'b0100);
      chk("sb_start", st_w[0], 1);
      chk("sb_data", dat_w[0], 8'hA5);
      chk("sb_gnt", gnt_w[0], 2);
      chk("sb_busy", busy_w[0], 1);
      rv = '0; rd = 32'h003C_0000;
      cyc(20); tick = 1'b1; cyc(1); tick = 1'b0;
      cyc(159); tick = 1'b1; cyc(1); tick = 1'b0;
      chk("sb_frame_done", fd_w[0], 1);
      chk("sb_busy_low", busy_w[0], 0);
      cyc(1);
      chk("sb_fd_pulse", fd_w[0], 0);
      chk("sb_data_hold", dat_w[0], 8'hA5);

      // round robin with all four requesters valid
      do_reset();
      rv = 4'hF; rd = 32'h4332_2110;
      last_end = 0;
      for (int g = 0; g < 5; g++) begin
         wait_start(0, "rr_start");
         chk("rr_order", 32'(gnt_w[0]), g % 4);
         chk("rr_data", dat_w[0], 8'h10 + 8'h11 * (g % 4));
         if (g > 0) chk("rr_spacing", cyc_n - last_end + 1, 2);
         two_ticks();
         chk("rr_frame_done", fd_w[0], 1);
         last_end = cyc_n;
      end
      rv = '0;

      // pointer wrap after a grant to requester 3
      do_reset();
      rv = 4'b1000;
      wait_start(0, "wrap_start3");
      chk("wrap_gnt3", gnt_w[0], 3);
      rv = 4'b0011;
      two_ticks();
      wait_start(0, "wrap_start0");
      chk("wrap_gnt0", gnt_w[0], 0);
      two_ticks();
      wait_start(0, "wrap_start1");
      chk("wrap_gnt1", gnt_w[0], 1);
      rv = '0;
      two_ticks();

      // watchdog on the 32-cycle instance
      do_reset();
      rv = 4'b0001;
      cyc(1);
      chk("wd_start", st_w[1], 1);
      rv = '0;
      cyc(32);
      chk("wd_early", to_w[1], 0);
      cyc(1);
      chk("wd_err", to_w[1], 1);
      chk("wd_no_fd", fd_w[1], 0);
      chk("wd_idle", busy_w[1], 0);
      rv = 4'b0100;
      wait_start(1, "wd_regrant");
      chk("wd_regrant_gnt", gnt_w[1], 2);
      rv = '0;

      // final tick on the last watchdog cycle: completion wins
      do_reset();
      rv = 4'b0001;
      cyc(1);
      rv = '0;
      cyc(4); tick = 1'b1; cyc(1); tick = 1'b0;
      cyc(27); tick = 1'b1; cyc(1); tick = 1'b0;
      chk("race_fd", fd_w[1], 1);
      chk("race_no_err", to_w[1], 0);

      // reset mid-frame; pointer returns to 0
      do_reset();
      rv = 4'b0100; rd = 32'h0077_0011;
      cyc(1);
      chk("rst_first_gnt", gnt_w[0], 2);
      cyc(3);
      rv = 4'b0101;
      rst = 1'b1;
      cyc(1);
      chk("rst_outs", {rdy_w[0], st_w[0], dat_w[0], busy_w[0], gnt_w[0], fd_w[0], to_w[0]}, 0);
      rst = 1'b0;
      cyc(1);
      chk("rst_gnt0", gnt_w[0], 0);
      chk("rst_ready0", rdy_w[0], 4'b0001);
      rv = '0;
      two_ticks();

      // randomized traffic, then a stretch with rare ticks to reach the watchdogs
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 3) == 0) rv = NR'($urandom);
         rd   = $urandom;
         tick = ($urandom_range(0, 5) == 0);
         rst  = ($urandom_range(0, 599) == 0);
         cyc(1);
      end
      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 7) == 0) rv = NR'($urandom);
         rd   = $urandom;
         tick = ($urandom_range(0, 150) == 0);
         rst  = 1'b0;
         cyc(1);
      end
      rst = 1'b0; rv = '0; tick = 1'b0;
      cyc(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
